// File: rtl/battle_resolver.sv
// Turn-based combat engine: latches hero/enemy stats on start, alternates hits,
// and holds the outcome, remaining HP, rounds and gold reward until the next battle.
module battle_resolver #(
  parameter int unsigned HP_W      = 12,
  parameter int unsigned STAT_W    = 8,
  parameter int unsigned GOLD_W    = 10,
  parameter int unsigned RND_W     = 8,
  parameter int unsigned STEP_MODE = 0
) (
  input  logic              clk_100mhz,
  input  logic              rst,
  input  logic              start,
  input  logic              step,
  input  logic              abort,
  input  logic [HP_W-1:0]   hero_hp_in,
  input  logic [STAT_W-1:0] hero_atk_in,
  input  logic [STAT_W-1:0] hero_def_in,
  input  logic [HP_W-1:0]   enemy_hp_in,
  input  logic [STAT_W-1:0] enemy_atk_in,
  input  logic [STAT_W-1:0] enemy_def_in,
  input  logic [GOLD_W-1:0] enemy_gold_in,
  output logic              busy,
  output logic              done,
  output logic              win,
  output logic              blocked,
  output logic              fled,
  output logic [HP_W-1:0]   hero_hp_out,
  output logic [HP_W-1:0]   enemy_hp_out,
  output logic [RND_W-1:0]  rounds,
  output logic [GOLD_W-1:0] gold_out
);

  localparam logic [RND_W-1:0] RND_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HERO  = 2'd1,
    ENEMY = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [STAT_W-1:0] hero_atk_q, hero_atk_d;
  logic [STAT_W-1:0] hero_def_q, hero_def_d;
  logic [STAT_W-1:0] enemy_atk_q, enemy_atk_d;
  logic [STAT_W-1:0] enemy_def_q, enemy_def_d;
  logic [GOLD_W-1:0] enemy_gold_q, enemy_gold_d;

  logic [HP_W-1:0]   hero_hp_q, hero_hp_d;
  logic [HP_W-1:0]   enemy_hp_q, enemy_hp_d;
  logic [RND_W-1:0]  rounds_q, rounds_d;
  logic [GOLD_W-1:0] gold_q, gold_d;
  logic              win_q, win_d;
  logic              blocked_q, blocked_d;
  logic              fled_q, fled_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [HP_W-1:0]   dmg_h_c, dmg_e_c, dmg_h_in_c;
  logic [HP_W-1:0]   enemy_hp_hit_c, hero_hp_hit_c;
  logic [RND_W-1:0]  rounds_inc_c;
  logic              advance_c;

  // Damage from latched stats, plus the start-time hero damage from raw inputs
  always_comb begin
    dmg_h_c    = (hero_atk_q > enemy_def_q) ? HP_W'(hero_atk_q - enemy_def_q) : '0;
    dmg_e_c    = (enemy_atk_q > hero_def_q) ? HP_W'(enemy_atk_q - hero_def_q) : '0;
    dmg_h_in_c = (hero_atk_in > enemy_def_in) ? HP_W'(hero_atk_in - enemy_def_in) : '0;
    enemy_hp_hit_c = (enemy_hp_q > dmg_h_c) ? HP_W'(enemy_hp_q - dmg_h_c) : '0;
    hero_hp_hit_c  = (hero_hp_q > dmg_e_c) ? HP_W'(hero_hp_q - dmg_e_c) : '0;
    rounds_inc_c   = RND_W'(rounds_q + RND_W'(1));
    advance_c      = (STEP_MODE == 0) || step;
  end

  always_comb begin
    state_d      = state_q;
    hero_atk_d   = hero_atk_q;
    hero_def_d   = hero_def_q;
    enemy_atk_d  = enemy_atk_q;
    enemy_def_d  = enemy_def_q;
    enemy_gold_d = enemy_gold_q;
    hero_hp_d    = hero_hp_q;
    enemy_hp_d   = enemy_hp_q;
    rounds_d     = rounds_q;
    gold_d       = gold_q;
    win_d        = win_q;
    blocked_d    = blocked_q;
    fled_d       = fled_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          hero_atk_d   = hero_atk_in;
          hero_def_d   = hero_def_in;
          enemy_atk_d  = enemy_atk_in;
          enemy_def_d  = enemy_def_in;
          enemy_gold_d = enemy_gold_in;
          hero_hp_d    = hero_hp_in;
          enemy_hp_d   = enemy_hp_in;
          rounds_d     = '0;
          gold_d       = '0;
          win_d        = 1'b0;
          blocked_d    = 1'b0;
          fled_d       = 1'b0;
          if (enemy_hp_in == '0) begin
            state_d = DONE;
            win_d   = 1'b1;
            gold_d  = enemy_gold_in;
          end else if (dmg_h_in_c == '0) begin
            state_d   = DONE;
            blocked_d = 1'b1;
          end else begin
            state_d = HERO;
          end
        end
      end
      HERO: begin
        if (abort) begin
          state_d = DONE;
          fled_d  = 1'b1;
          win_d   = 1'b0;
        end else if (advance_c) begin
          enemy_hp_d = enemy_hp_hit_c;
          if (enemy_hp_hit_c == '0) begin
            state_d = DONE;
            win_d   = 1'b1;
            gold_d  = enemy_gold_q;
          end else begin
            state_d = ENEMY;
          end
        end
      end
      ENEMY: begin
        if (abort) begin
          state_d = DONE;
          fled_d  = 1'b1;
          win_d   = 1'b0;
        end else if (advance_c) begin
          hero_hp_d = hero_hp_hit_c;
          rounds_d  = rounds_inc_c;
          // Hero death and round timeout both end the battle as a loss
          if (hero_hp_hit_c == '0 || rounds_inc_c == RND_MAX) begin
            state_d = DONE;
            win_d   = 1'b0;
          end else begin
            state_d = HERO;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == HERO) || (state_d == ENEMY);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      state_q      <= IDLE;
      hero_atk_q   <= '0;
      hero_def_q   <= '0;
      enemy_atk_q  <= '0;
      enemy_def_q  <= '0;
      enemy_gold_q <= '0;
      hero_hp_q    <= '0;
      enemy_hp_q   <= '0;
      rounds_q     <= '0;
      gold_q       <= '0;
      win_q        <= 1'b0;
      blocked_q    <= 1'b0;
      fled_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      hero_atk_q   <= hero_atk_d;
      hero_def_q   <= hero_def_d;
      enemy_atk_q  <= enemy_atk_d;
      enemy_def_q  <= enemy_def_d;
      enemy_gold_q <= enemy_gold_d;
      hero_hp_q    <= hero_hp_d;
      enemy_hp_q   <= enemy_hp_d;
      rounds_q     <= rounds_d;
      gold_q       <= gold_d;
      win_q        <= win_d;
      blocked_q    <= blocked_d;
      fled_q       <= fled_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign win          = win_q;
  assign blocked      = blocked_q;
  assign fled         = fled_q;
  assign hero_hp_out  = hero_hp_q;
  assign enemy_hp_out = enemy_hp_q;
  assign rounds       = rounds_q;
  assign gold_out     = gold_q;

endmodule

// File: tb/tb_battle_resolver.sv
// Directed bench for battle_resolver: auto mode, step mode and a 2-bit round
// counter instance share stimulus; each battle is started on one instance only.
module tb_battle_resolver;

  logic        clk = 1'b0;
  logic        rst, step, abort;
  logic        start_a, start_s, start_t;
  logic [11:0] hhp_in, ehp_in;
  logic [7:0]  hatk_in, hdef_in, eatk_in, edef_in;
  logic [9:0]  gold_in;

  logic        busy_a, done_a, win_a, blocked_a, fled_a;
  logic [11:0] hhp_a, ehp_a;
  logic [7:0]  rnd_a;
  logic [9:0]  gold_a;

  logic        busy_s, done_s, win_s, blocked_s, fled_s;
  logic [11:0] hhp_s, ehp_s;
  logic [7:0]  rnd_s;
  logic [9:0]  gold_s;

  logic        busy_t, done_t, win_t, blocked_t, fled_t;
  logic [11:0] hhp_t, ehp_t;
  logic [1:0]  rnd_t;
  logic [9:0]  gold_t;

  int total = 0;
  int bad   = 0;
  int exp_e, exp_h;

  always #5 clk = ~clk;

  battle_resolver dut_a (
    .clk_100mhz(clk), .rst(rst), .start(start_a), .step(step), .abort(abort),
    .hero_hp_in(hhp_in), .hero_atk_in(hatk_in), .hero_def_in(hdef_in),
    .enemy_hp_in(ehp_in), .enemy_atk_in(eatk_in), .enemy_def_in(edef_in),
    .enemy_gold_in(gold_in), .busy(busy_a), .done(done_a), .win(win_a),
    .blocked(blocked_a), .fled(fled_a), .hero_hp_out(hhp_a), .enemy_hp_out(ehp_a),
    .rounds(rnd_a), .gold_out(gold_a)
  );

  battle_resolver #(.STEP_MODE(1)) dut_s (
    .clk_100mhz(clk), .rst(rst), .start(start_s), .step(step), .abort(abort),
    .hero_hp_in(hhp_in), .hero_atk_in(hatk_in), .hero_def_in(hdef_in),
    .enemy_hp_in(ehp_in), .enemy_atk_in(eatk_in), .enemy_def_in(edef_in),
    .enemy_gold_in(gold_in), .busy(busy_s), .done(done_s), .win(win_s),
    .blocked(blocked_s), .fled(fled_s), .hero_hp_out(hhp_s), .enemy_hp_out(ehp_s),
    .rounds(rnd_s), .gold_out(gold_s)
  );

  battle_resolver #(.RND_W(2)) dut_t (
    .clk_100mhz(clk), .rst(rst), .start(start_t), .step(step), .abort(abort),
    .hero_hp_in(hhp_in), .hero_atk_in(hatk_in), .hero_def_in(hdef_in),
    .enemy_hp_in(ehp_in), .enemy_atk_in(eatk_in), .enemy_def_in(edef_in),
    .enemy_gold_in(gold_in), .busy(busy_t), .done(done_t), .win(win_t),
    .blocked(blocked_t), .fled(fled_t), .hero_hp_out(hhp_t), .enemy_hp_out(ehp_t),
    .rounds(rnd_t), .gold_out(gold_t)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_stats(input int hh, input int ha, input int hd,
                           input int eh, input int ea, input int ed, input int g);
    hhp_in  = 12'(hh); hatk_in = 8'(ha); hdef_in = 8'(hd);
    ehp_in  = 12'(eh); eatk_in = 8'(ea); edef_in = 8'(ed);
    gold_in = 10'(g);
  endtask

  initial begin
    rst = 1'b1; step = 1'b0; abort = 1'b0;
    start_a = 1'b0; start_s = 1'b0; start_t = 1'b0;
    set_stats(0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    rst = 1'b0;
    check("rst_busy", 32'(busy_a), 0);
    check("rst_done", 32'(done_a), 0);
    check("rst_hhp", 32'(hhp_a), 0);
    check("rst_rounds", 32'(rnd_a), 0);

    // Auto-mode win
    set_stats(100, 20, 5, 50, 15, 10, 30);
    start_a = 1'b1; tick(); start_a = 1'b0;
    check("t1_busy0", 32'(busy_a), 1);
    check("t1_ehp0", 32'(ehp_a), 50);
    for (int e = 1; e <= 9; e++) begin
      tick();
      if (e % 2 == 1) check($sformatf("t1_ehp_e%0d", e), 32'(ehp_a), 32'(50 - 10 * ((e + 1) / 2)));
      else check($sformatf("t1_hhp_e%0d", e), 32'(hhp_a), 32'(100 - 10 * (e / 2)));
    end
    check("t1_done", 32'(done_a), 1);
    check("t1_busy", 32'(busy_a), 0);
    check("t1_win", 32'(win_a), 1);
    check("t1_hhp", 32'(hhp_a), 60);
    check("t1_rounds", 32'(rnd_a), 4);
    check("t1_gold", 32'(gold_a), 30);
    tick();
    check("t1_done_once", 32'(done_a), 0);
    check("t1_win_hold", 32'(win_a), 1);
    check("t1_gold_hold", 32'(gold_a), 30);

    // Abort in ENEMY, with a start pulse during HERO
    start_a = 1'b1; tick();
    tick(); start_a = 1'b0;
    check("t5_ehp_nolatch", 32'(ehp_a), 40);
    abort = 1'b1; tick(); abort = 1'b0;
    check("t5_done", 32'(done_a), 1);
    check("t5_fled", 32'(fled_a), 1);
    check("t5_win", 32'(win_a), 0);
    check("t5_ehp", 32'(ehp_a), 40);
    check("t5_hhp", 32'(hhp_a), 100);
    check("t5_gold", 32'(gold_a), 0);
    tick();
    check("t5_done_once", 32'(done_a), 0);
    check("t5_idle", 32'(busy_a), 0);

    // Loss with hero HP saturating at zero
    set_stats(10, 20, 0, 100, 15, 0, 30);
    start_a = 1'b1; tick(); start_a = 1'b0;
    tick();
    check("t2_ehp1", 32'(ehp_a), 80);
    tick();
    check("t2_done", 32'(done_a), 1);
    check("t2_win", 32'(win_a), 0);
    check("t2_fled", 32'(fled_a), 0);
    check("t2_hhp", 32'(hhp_a), 0);
    check("t2_rounds", 32'(rnd_a), 1);
    check("t2_gold", 32'(gold_a), 0);
    check("t2_ehp", 32'(ehp_a), 80);
    tick();

    // Blocked: hero attack equals enemy defence
    set_stats(100, 10, 0, 50, 15, 10, 30);
    start_a = 1'b1; tick(); start_a = 1'b0;
    check("t3_done", 32'(done_a), 1);
    check("t3_blocked", 32'(blocked_a), 1);
    check("t3_win", 32'(win_a), 0);
    check("t3_rounds", 32'(rnd_a), 0);
    check("t3_hhp", 32'(hhp_a), 100);
    check("t3_ehp", 32'(ehp_a), 50);
    tick();

    // Enemy already dead
    set_stats(100, 20, 5, 0, 15, 10, 30);
    start_a = 1'b1; tick(); start_a = 1'b0;
    check("t3b_done", 32'(done_a), 1);
    check("t3b_win", 32'(win_a), 1);
    check("t3b_gold", 32'(gold_a), 30);
    check("t3b_blocked", 32'(blocked_a), 0);
    tick();

    // Step mode: one step pulse every third cycle
    set_stats(100, 20, 5, 50, 15, 10, 30);
    start_s = 1'b1; tick(); start_s = 1'b0;
    exp_e = 50; exp_h = 100;
    for (int i = 1; i <= 9; i++) begin
      tick(); tick();
      check($sformatf("t4_hold_e_%0d", i), 32'(ehp_s), 32'(exp_e));
      check($sformatf("t4_hold_h_%0d", i), 32'(hhp_s), 32'(exp_h));
      step = 1'b1; tick(); step = 1'b0;
      if (i % 2 == 1) exp_e = (exp_e > 10) ? exp_e - 10 : 0;
      else exp_h = (exp_h > 10) ? exp_h - 10 : 0;
      check($sformatf("t4_step_e_%0d", i), 32'(ehp_s), 32'(exp_e));
      check($sformatf("t4_step_h_%0d", i), 32'(hhp_s), 32'(exp_h));
      if (i < 9) check($sformatf("t4_notdone_%0d", i), 32'(done_s), 0);
    end
    check("t4_done", 32'(done_s), 1);
    check("t4_win", 32'(win_s), 1);
    check("t4_hhp", 32'(hhp_s), 60);
    check("t4_rounds", 32'(rnd_s), 4);
    check("t4_gold", 32'(gold_s), 30);
    tick();

    // Reset mid-battle
    start_a = 1'b1; tick(); start_a = 1'b0;
    tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    check("t6_busy", 32'(busy_a), 0);
    check("t6_hhp", 32'(hhp_a), 0);
    check("t6_ehp", 32'(ehp_a), 0);
    check("t6_rounds", 32'(rnd_a), 0);
    check("t6_win", 32'(win_a), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("t6_nodone_%0d", i), 32'(done_a), 0);
    end

    // Round timeout with a 2-bit counter
    set_stats(100, 1, 0, 100, 1, 0, 5);
    start_t = 1'b1; tick(); start_t = 1'b0;
    for (int e = 1; e <= 5; e++) tick();
    check("t6b_notdone", 32'(done_t), 0);
    tick();
    check("t6b_done", 32'(done_t), 1);
    check("t6b_win", 32'(win_t), 0);
    check("t6b_rounds", 32'(rnd_t), 3);
    check("t6b_hhp", 32'(hhp_t), 97);
    check("t6b_ehp", 32'(ehp_t), 97);
    check("t6b_gold", 32'(gold_t), 0);
    check("t6b_fled", 32'(fled_t), 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/battle_resolver.md
Name: battle_resolver

Overview:
Parametrised turn-based combat engine for the BattleField game core. It replaces the fixed-width single-step battle logic in main. On a start pulse it latches hero and enemy stats, then alternates hero and enemy hits, one hit per active clock edge. In step mode it advances one hit per player key pulse instead. When the fight ends it reports the outcome, the remaining HP, the rounds fought and the gold earned, and holds those results for the map/shop logic.

Parameters:
HP_W, 12, width of every HP value
STAT_W, 8, width of the attack and defence values
GOLD_W, 10, width of the gold reward
RND_W, 8, width of the round counter; a battle times out after 2^RND_W-1 rounds
STEP_MODE, 0, 0 = auto-advance every cycle; 1 = advance only on cycles where step=1

Ports:
clk_100mhz  in  1  system clock; all logic is on the rising edge
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle request to begin a battle; sampled only in IDLE
step  in  1  advance pulse (the enter key); used only when STEP_MODE=1
abort  in  1  flee request; honoured in HERO and ENEMY
hero_hp_in / hero_atk_in / hero_def_in  in  HP_W/STAT_W/STAT_W  hero stats, latched on start
enemy_hp_in / enemy_atk_in / enemy_def_in  in  HP_W/STAT_W/STAT_W  enemy stats, latched on start
enemy_gold_in  in  GOLD_W  reward, latched on start
busy  out  1  high in HERO and ENEMY
done  out  1  high for exactly one cycle, in DONE
win  out  1  hero defeated the enemy
blocked  out  1  battle refused because hero damage is 0
fled  out  1  battle ended by abort
hero_hp_out  out  HP_W  hero HP, live during the battle, final after it
enemy_hp_out  out  HP_W  enemy HP, live during the battle, final after it
rounds  out  RND_W  count of completed enemy turns
gold_out  out  GOLD_W  enemy_gold if win, else 0

Behaviour:
- Reset: state=IDLE; every output is 0. Reset mid-battle aborts immediately with no done pulse.
- Damage is combinational from the latched stats:
  - dmg_h = (hero_atk > enemy_def) ? hero_atk - enemy_def : 0
  - dmg_e = (enemy_atk > hero_def) ? enemy_atk - hero_def : 0
  - Both are zero-extended to HP_W.
- HP subtraction saturates at 0 and never wraps.
- IDLE, start=1 at edge k: latch all inputs into hero_hp_out, enemy_hp_out and the internal stat registers. On the same edge, clear win, blocked, fled, rounds and gold_out. Then choose the next state by priority:
  1. enemy_hp_in==0 → DONE, win=1, gold_out=enemy_gold_in.
  2. Else dmg_h==0 → DONE, blocked=1.
  3. Else → HERO.
- HERO, on an advancing edge (every edge if STEP_MODE=0; edges with step=1 if STEP_MODE=1):
  - Perform enemy_hp_out -= dmg_h.
  - If the result is 0 → DONE, win=1, gold_out=enemy_gold.
  - Else → ENEMY.
- ENEMY, on an advancing edge:
  - Perform hero_hp_out -= dmg_e and rounds += 1.
  - If hero_hp_out is now 0 → DONE, win=0.
  - Else if rounds is now 2^RND_W-1 → DONE, win=0 (timeout).
  - Else → HERO.
- abort=1 in HERO or ENEMY: → DONE, fled=1, win=0, with no HP change on that edge. abort has priority over step and over the hit. abort in IDLE or DONE is ignored.
- DONE: done=1 and busy=0 for one cycle, then unconditional → IDLE. start is ignored while in DONE.
- start while busy is ignored; the latched stats never change mid-battle.
- All result outputs hold their values in IDLE until the next accepted start.
- In step mode, a non-advancing cycle holds all state. step in auto mode is ignored.
- Latency: the hero hits at edge k+1. For a battle ending on hero hit n, done is high in the cycle after edge k+2n-1.

Test Plan:
1. Auto win, hero 100/20/5 vs enemy 50/15/10/gold 30, start at edge 0 → enemy HP 40,30,20,10,0 at edges 1,3,5,7,9; done high after edge 9; win=1, hero_hp_out=60, rounds=4, gold_out=30, busy low in the done cycle.
2. Loss, hero 10/20/0 vs enemy 100/15/0 → hero_hp_out=0 after edge 2; done, win=0, rounds=1, gold_out=0, enemy_hp_out=80.
3. Blocked and trivial cases:
   - hero_atk=10, enemy_def=10 → DONE on the edge after start; blocked=1, win=0, rounds=0, HP unchanged.
   - enemy_hp_in=0 → win=1 with no hits.
4. Step mode (STEP_MODE=1), case 1 stats, step pulsed every 3rd cycle → the same final values as case 1. HP changes only on step edges, and done follows the 9th step.
5. Abort and start-while-busy: abort asserted in ENEMY after one hero hit → fled=1, win=0, enemy_hp_out=40, hero_hp_out=100, one done pulse. A start pulse asserted mid-battle has no effect.
6. Reset and timeout:
   - rst mid-battle → all outputs 0 on the next cycle and no done pulse.
   - RND_W=2, with both sides dealing 1 damage and both at 100 HP → timeout after rounds=3 with win=0.
